// File: rtl/bus_pkg.sv
// Shared types and helpers for the MMIO crossbar: FSM states, size/alignment check
// and byte-lane strobe generation.
package bus_pkg;

  localparam int DEF_NSLV   = 3;
  localparam int DEF_ADDR_W = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Legal sizes are 1/2/4/8 bytes, naturally aligned within the 8-byte word.
  function automatic logic size_ok(input logic [7:0] bytes, input logic [2:0] off);
    logic       legal;
    logic [7:0] amask;
    legal   = (bytes == 8'd1) || (bytes == 8'd2) || (bytes == 8'd4) || (bytes == 8'd8);
    amask   = bytes - 8'd1;
    size_ok = legal && ((off & amask[2:0]) == 3'd0);
  endfunction

  function automatic logic [7:0] strb_gen(input logic [7:0] bytes, input logic [2:0] off);
    logic [15:0] m;
    m        = (16'd1 << bytes) - 16'd1;
    m        = m << off;
    strb_gen = m[7:0];
  endfunction

endpackage

// File: rtl/mmio_xbar_if.sv
// CPU access port and slave fan-out bundles; master drives the request, slave answers.
interface acs_if;
  logic        acs_en;
  logic        acs_wr;
  logic [7:0]  acs_bytes;
  logic [63:0] acs_addr;
  logic [63:0] acs_wdata;
  logic        acs_ready;
  logic [63:0] acs_rdata;
  logic        acs_error;

  modport master (output acs_en, acs_wr, acs_bytes, acs_addr, acs_wdata,
                  input  acs_ready, acs_rdata, acs_error);
  modport slave  (input  acs_en, acs_wr, acs_bytes, acs_addr, acs_wdata,
                  output acs_ready, acs_rdata, acs_error);
endinterface

interface slv_if #(
  parameter int NSLV   = bus_pkg::DEF_NSLV,
  parameter int ADDR_W = bus_pkg::DEF_ADDR_W
);
  logic [NSLV-1:0]    slv_cen;
  logic               slv_wr;
  logic [7:0]         slv_strb;
  logic [ADDR_W-1:0]  slv_addr;
  logic [63:0]        slv_wdata;
  logic [NSLV-1:0]    slv_ack;
  logic [NSLV*64-1:0] slv_rdata;
  logic [NSLV-1:0]    slv_error;

  modport master (output slv_cen, slv_wr, slv_strb, slv_addr, slv_wdata,
                  input  slv_ack, slv_rdata, slv_error);
  modport slave  (input  slv_cen, slv_wr, slv_strb, slv_addr, slv_wdata,
                  output slv_ack, slv_rdata, slv_error);
endinterface

// File: rtl/xbar_decoder.sv
// Combinational address decode against base/mask tables; lowest matching index wins.
// Zero latency, no flow control.
module xbar_decoder #(
  parameter int                 NSLV     = 3,
  parameter int                 ADDR_W   = 27,
  parameter logic [NSLV*64-1:0] SLV_BASE = '0,
  parameter logic [NSLV*64-1:0] SLV_MASK = '0
) (
  input  logic [63:0]       addr_i,
  output logic [NSLV-1:0]   sel_o,
  output logic              hit_o,
  output logic [ADDR_W-1:0] offset_o
);

  // Scan from the top so the lowest matching index overwrites the others.
  always_comb begin
    sel_o    = '0;
    hit_o    = 1'b0;
    offset_o = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*64 +: 64]) == SLV_BASE[i*64 +: 64]) begin
        sel_o    = '0;
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
        offset_o = ADDR_W'(addr_i & ~SLV_MASK[i*64 +: 64]);
      end
    end
  end

endmodule

// File: rtl/mmio_xbar.sv
// CPU-to-slave MMIO interconnect: ready 2 cycles after acs_en for a zero-wait slave, 1 on decode error.
// Master holds acs_en until acs_ready; slaves stall via late slv_ack, bounded by the TMO_CYCLES watchdog.
module mmio_xbar
  import bus_pkg::*;
#(
  parameter int                 NSLV       = DEF_NSLV,
  parameter int                 ADDR_W     = DEF_ADDR_W,
  // Slave 0 (memory) sits in the LSBs, then uart, then timer.
  parameter logic [NSLV*64-1:0] SLV_BASE   = {64'ha000_0048, 64'ha000_03f8, 64'h8000_0000},
  parameter logic [NSLV*64-1:0] SLV_MASK   = {64'hffff_ffff_ffff_fff8, 64'hffff_ffff_ffff_fff8,
                                              64'hffff_ffff_f800_0000},
  parameter int                 TMO_CYCLES = 255
) (
  input  logic  clk,
  input  logic  rstn,
  acs_if.slave  acs,
  slv_if.master slv
);

  localparam int                CNT_W   = $clog2(TMO_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TMO_CYCLES);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NSLV-1:0]   sel_q;
  logic [NSLV-1:0]   cen_q;
  logic              wr_q;
  logic [7:0]        strb_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              ready_q;
  logic              error_q;

  logic [NSLV-1:0]   dec_sel;
  logic              dec_hit;
  logic [ADDR_W-1:0] dec_off;
  logic              acc_ok;
  logic              ack_hit;
  logic [63:0]       ack_rdata;
  logic              ack_err;

  xbar_decoder #(
    .NSLV    (NSLV),
    .ADDR_W  (ADDR_W),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK)
  ) u_dec (
    .addr_i  (acs.acs_addr),
    .sel_o   (dec_sel),
    .hit_o   (dec_hit),
    .offset_o(dec_off)
  );

  assign acc_ok = dec_hit && size_ok(acs.acs_bytes, acs.acs_addr[2:0]);

  // Only the latched target may complete the access; stray acks are masked here.
  always_comb begin
    ack_hit   = |(slv.slv_ack & sel_q);
    ack_rdata = '0;
    ack_err   = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (sel_q[i]) begin
        ack_rdata = slv.slv_rdata[i*64 +: 64];
        ack_err   = slv.slv_error[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      cen_q   <= '0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      cen_q   <= '0;
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (acs.acs_en) begin
            if (acc_ok) begin
              state_q <= ST_REQ;
              sel_q   <= dec_sel;
              cen_q   <= dec_sel;
              wr_q    <= acs.acs_wr;
              strb_q  <= strb_gen(acs.acs_bytes, acs.acs_addr[2:0]);
              addr_q  <= dec_off;
              wdata_q <= acs.acs_wdata;
            end else begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              error_q <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ST_REQ: begin
          if (ack_hit) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= ack_rdata;
            error_q <= ack_err;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (ack_hit) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= ack_rdata;
            error_q <= ack_err;
          end else if (cnt_q == TMO_VAL) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            rdata_q <= '0;
            error_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
          sel_q   <= '0;
          wr_q    <= 1'b0;
          strb_q  <= '0;
          addr_q  <= '0;
          wdata_q <= '0;
          rdata_q <= '0;
          error_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acs.acs_ready = ready_q;
  assign acs.acs_rdata = rdata_q;
  assign acs.acs_error = error_q;
  assign slv.slv_cen   = cen_q;
  assign slv.slv_wr    = wr_q;
  assign slv.slv_strb  = strb_q;
  assign slv.slv_addr  = addr_q;
  assign slv.slv_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_xbar.sv
// Directed bench for mmio_xbar: slave models with programmable ack delay, scoreboard
// queues for expected slave requests and CPU responses.
module tb_mmio_xbar;
  import bus_pkg::*;

  localparam int NSLV   = 3;
  localparam int ADDR_W = 27;
  localparam int TMO    = 4;

  typedef struct {
    logic [NSLV-1:0] cen;
    logic            wr;
    logic [7:0]      strb;
    logic [63:0]     addr;
    logic [63:0]     wdata;
    int              edg;
  } cen_exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          edg;
  } rsp_exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_cnt = 0;
  int   spur_edge = -1;

  int          dly   [NSLV];
  logic [63:0] mdata [NSLV];
  logic        merr  [NSLV];
  logic        busy  [NSLV];
  int          ctr   [NSLV];

  cen_exp_t cen_q[$];
  rsp_exp_t rsp_q[$];

  acs_if acs ();
  slv_if #(.NSLV(NSLV), .ADDR_W(ADDR_W)) slv ();

  mmio_xbar #(
    .NSLV      (NSLV),
    .ADDR_W    (ADDR_W),
    .TMO_CYCLES(TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .acs (acs),
    .slv (slv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave models: ack in the strobe cycle (dly 0), dly cycles later, or never (dly < 0).
  always_comb begin
    slv.slv_ack   = '0;
    slv.slv_rdata = '0;
    slv.slv_error = '0;
    for (int i = 0; i < NSLV; i++) begin
      slv.slv_ack[i] = (dly[i] == 0 && slv.slv_cen[i]) || (busy[i] && ctr[i] == dly[i]) ||
                       (i == 1 && spur_edge == cyc + 1);
      slv.slv_rdata[i*64 +: 64] = mdata[i];
      slv.slv_error[i]          = merr[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NSLV; i++) begin
      if (!rstn) begin
        busy[i] <= 1'b0;
        ctr[i]  <= 0;
      end else if (slv.slv_cen[i] && dly[i] > 0) begin
        busy[i] <= 1'b1;
        ctr[i]  <= 1;
      end else if (busy[i]) begin
        if (ctr[i] == dly[i]) busy[i] <= 1'b0;
        else ctr[i] <= ctr[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_acs_ready"}, 64'(acs.acs_ready), 0);
    chk({tag, "_acs_rdata"}, acs.acs_rdata, 0);
    chk({tag, "_acs_error"}, 64'(acs.acs_error), 0);
    chk({tag, "_slv_cen"},   64'(slv.slv_cen), 0);
    chk({tag, "_slv_wr"},    64'(slv.slv_wr), 0);
    chk({tag, "_slv_strb"},  64'(slv.slv_strb), 0);
    chk({tag, "_slv_addr"},  64'(slv.slv_addr), 0);
    chk({tag, "_slv_wdata"}, slv.slv_wdata, 0);
  endtask

  // Slave-request monitor: every strobe must match the next expected request.
  initial forever begin
    @(negedge clk);
    if (slv.slv_cen != '0) begin
      if (cen_q.size() == 0) begin
        chk("unexpected_cen", 64'(slv.slv_cen), 0);
      end else begin
        cen_exp_t e;
        e = cen_q.pop_front();
        chk("cen",       64'(slv.slv_cen), 64'(e.cen));
        chk("cen_cycle", 64'(cyc + 1), 64'(e.edg));
        chk("slv_wr",    64'(slv.slv_wr), 64'(e.wr));
        chk("slv_strb",  64'(slv.slv_strb), 64'(e.strb));
        chk("slv_addr",  64'(slv.slv_addr), e.addr);
        chk("slv_wdata", slv.slv_wdata, e.wdata);
      end
    end
  end

  // CPU-response monitor.
  initial forever begin
    @(negedge clk);
    if (acs.acs_ready) begin
      ready_cnt++;
      if (rsp_q.size() == 0) begin
        chk("unexpected_ready", 64'(acs.acs_ready), 0);
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        chk("rsp_rdata", acs.acs_rdata, e.rdata);
        chk("rsp_error", 64'(acs.acs_error), 64'(e.err));
        chk("rsp_cycle", 64'(cyc + 1), 64'(e.edg));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the response cycle.
  task automatic access(input logic wr, input logic [7:0] bytes, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [NSLV-1:0] exp_cen,
                        input logic [7:0] exp_strb, input logic [63:0] exp_saddr, input int lat,
                        input logic [63:0] exp_rdata, input logic exp_err, output int rdy_edge);
    int n;
    bit seen;
    n             = cyc + 1;
    rdy_edge      = -1;
    acs.acs_en    = 1'b1;
    acs.acs_wr    = wr;
    acs.acs_bytes = bytes;
    acs.acs_addr  = addr;
    acs.acs_wdata = wdata;
    if (exp_cen != '0) cen_q.push_back('{exp_cen, wr, exp_strb, exp_saddr, wdata, n + 1});
    rsp_q.push_back('{exp_rdata, exp_err, n + lat});
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (acs.acs_ready) begin
        seen     = 1'b1;
        rdy_edge = cyc + 1;
      end
    end
    chk("ready_seen", 64'(seen), 1);
    @(posedge clk);
    #1;
    acs.acs_en    = 1'b0;
    acs.acs_wr    = 1'b0;
    acs.acs_bytes = '0;
    acs.acs_addr  = '0;
    acs.acs_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r1, r2, n, rc;
    rstn          = 1'b1;
    acs.acs_en    = 1'b0;
    acs.acs_wr    = 1'b0;
    acs.acs_bytes = '0;
    acs.acs_addr  = '0;
    acs.acs_wdata = '0;
    dly   = '{0, 0, -1};
    mdata = '{64'h0, 64'h0, 64'h0};
    merr  = '{1'b0, 1'b0, 1'b0};
    #2 rstn = 1'b0;
    #3 chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(posedge clk);
    #1;

    // 8-byte memory read, zero-wait
    mdata[0] = 64'h1122_3344_5566_7788;
    access(1'b0, 8'd8, 64'h8000_0010, 64'h0, 3'b001, 8'hff, 64'h10, 2, 64'h1122_3344_5566_7788,
           1'b0, r);

    // 1-byte uart write
    access(1'b1, 8'd1, 64'ha000_03f8, 64'h41, 3'b010, 8'h01, 64'h0, 2, 64'h0, 1'b0, r);

    // decode errors: unmapped, misaligned, illegal size
    access(1'b0, 8'd4, 64'h1000_0000, 64'h0, 3'b000, 8'h00, 64'h0, 1, 64'h0, 1'b1, r);
    access(1'b0, 8'd4, 64'h8000_0002, 64'h0, 3'b000, 8'h00, 64'h0, 1, 64'h0, 1'b1, r);
    access(1'b0, 8'd3, 64'h8000_0000, 64'h0, 3'b000, 8'h00, 64'h0, 1, 64'h0, 1'b1, r);

    // timer never acks: watchdog error with zero data
    mdata[2] = 64'hdead_beef_dead_beef;
    access(1'b0, 8'd8, 64'ha000_0048, 64'h0, 3'b100, 8'hff, 64'h0, 2 + TMO, 64'h0, 1'b1, r);

    // memory recovers: 4-byte read in the upper half-word
    mdata[0] = 64'hcafe_f00d_0123_4567;
    access(1'b0, 8'd4, 64'h8000_0104, 64'h0, 3'b001, 8'hf0, 64'h104, 2, 64'hcafe_f00d_0123_4567,
           1'b0, r);

    // memory acks 3 cycles late with error; uart acks spuriously while memory is pending
    dly[0]    = 3;
    merr[0]   = 1'b1;
    mdata[0]  = 64'h0bad_0bad_0bad_0bad;
    mdata[1]  = 64'h5555_5555_5555_5555;
    merr[1]   = 1'b1;
    spur_edge = cyc + 4;
    access(1'b0, 8'd8, 64'h8000_0000, 64'h0, 3'b001, 8'hff, 64'h0, 5, 64'h0bad_0bad_0bad_0bad,
           1'b1, r);
    dly[0]    = 0;
    merr[0]   = 1'b0;
    merr[1]   = 1'b0;
    mdata[1]  = 64'h0;
    spur_edge = -1;

    // back-to-back zero-wait writes: one access per 3 cycles
    mdata[0] = 64'h0;
    access(1'b1, 8'd2, 64'h8000_0206, 64'h0000_abcd_0000_0000, 3'b001, 8'hc0, 64'h206, 2, 64'h0,
           1'b0, r1);
    access(1'b1, 8'd8, 64'h8000_0208, 64'h0102_0304_0506_0708, 3'b001, 8'hff, 64'h208, 2, 64'h0,
           1'b0, r2);
    chk("b2b_gap", 64'(r2 - r1), 3);

    // reset while waiting on the timer: pending access dropped, no ready afterwards
    n             = cyc + 1;
    acs.acs_en    = 1'b1;
    acs.acs_wr    = 1'b0;
    acs.acs_bytes = 8'd8;
    acs.acs_addr  = 64'ha000_0048;
    cen_q.push_back('{3'b100, 1'b0, 8'hff, 64'h0, 64'h0, n + 1});
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk_all_zero("rst_wait");
    rc            = ready_cnt;
    acs.acs_en    = 1'b0;
    acs.acs_bytes = '0;
    acs.acs_addr  = '0;
    @(posedge clk);
    #3 rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("no_ready_after_rst", 64'(ready_cnt), 64'(rc));

    // first access after reset
    mdata[0] = 64'h8877_6655_4433_2211;
    access(1'b0, 8'd8, 64'h8000_0018, 64'h0, 3'b001, 8'hff, 64'h18, 2, 64'h8877_6655_4433_2211,
           1'b0, r);

    repeat (3) @(posedge clk);
    chk("cen_q_drained", 64'(cen_q.size()), 0);
    chk("rsp_q_drained", 64'(rsp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
